// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, ALU-op and opcode definitions for the multicycle RV32I controller
package ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP
    } state_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_op_t;
    localparam alu_op_t ALU_PASSB = ALU_OR;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 to an ALU operation for register and immediate arithmetic
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_op
);
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000: alu_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM sequencing a multicycle RV32I datapath over one shared memory port
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       LogOut,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       trap
);
    state_t     state, next;
    logic [7:0] wait_cnt;
    logic [3:0] alu_dec;
    logic       timed_out;

    alu_decoder u_dec (
        .funct3  (funct3),
        .funct7b5(funct7b5),
        .is_rtype(state == EXECR),
        .alu_op  (alu_dec)
    );

    assign timed_out = (TIMEOUT != 0) && (wait_cnt == 8'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= next;
            wait_cnt <= (next != state || mem_ready) ? '0 : wait_cnt + 8'(mem_req);
        end
    end

    always_comb begin
        next       = state;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        trap       = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcB   = mem_ready ? 2'b10 : 2'b00;
                ResultSrc = mem_ready ? 2'b10 : 2'b00;
                next      = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next = MEMADR;
                    OP_R:              next = EXECR;
                    OP_I:              next = EXECI;
                    OP_BR:             next = BRANCH;
                    OP_JAL:            next = JAL;
                    OP_JALR:           next = JALR;
                    OP_LUI, OP_AUIPC:  next = UPPER;
                    default:           next = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
                next    = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                next    = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                next      = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                next     = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR, EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = state == EXECI ? 2'b01 : 2'b00;
                ALUControl = alu_dec;
                next       = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ImmSrc     = IMM_B;
                ALUControl = funct3[2] ? {2'b11, funct3[1:0]} : {3'b101, funct3[0]};
                PCWrite    = LogOut && funct3[2:1] != 2'b01;
                next       = funct3[2:1] == 2'b01 ? TRAP : FETCH;
            end
            JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = IMM_J;
                next    = ALUWB;
            end
            JALR: begin
                PCWrite   = 1'b1;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                next      = ALUWB;
            end
            UPPER: begin
                ImmSrc     = IMM_U;
                ALUSrcA    = op[5] ? 2'b10 : 2'b01;
                ALUSrcB    = 2'b01;
                ALUControl = op[5] ? ALU_PASSB : ALU_ADD;
                next       = ALUWB;
            end
            default: begin
                trap = 1'b1;
                next = TRAP;
            end
        endcase
        // a stalled access that hits the limit is abandoned with every enable dropped
        if (timed_out) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ImmSrc     = IMM_I;
            ALUControl = ALU_ADD;
            next       = TRAP;
        end
    end
endmodule
